// File: rtl/interrupt_controller.sv
// Vectored interrupt controller: edge-detected sources, mask register, fixed
// priority (highest index wins) and a single IDLE/REQ/SERVICE handshake with the CPU.
module interrupt_controller #(
    parameter  int ID_WIDTH = 3,
    localparam int IN_WIDTH = 1 << ID_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] src,
    input  logic                maskWe,
    input  logic [IN_WIDTH-1:0] maskIn,
    input  logic                irqAck,
    input  logic                eoi,
    output logic                irq,
    output logic [ID_WIDTH-1:0] vector,
    output logic [IN_WIDTH-1:0] pending,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    // Handshake: irq stays high from selection until irqAck is seen in REQ;
    // the CPU then owns the vector until it signals eoi in SERVICE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                irq_q, irq_d;
    logic [ID_WIDTH-1:0] vector_q, vector_d;
    logic [IN_WIDTH-1:0] pending_q, pending_d;
    logic [IN_WIDTH-1:0] mask_q, mask_d;
    logic [IN_WIDTH-1:0] src_prev_q, src_prev_d;

    logic [IN_WIDTH-1:0] rise;
    logic [IN_WIDTH-1:0] active;
    logic [IN_WIDTH-1:0] clr;
    logic [ID_WIDTH-1:0] sel;

    always_comb begin
        rise   = src & ~src_prev_q;
        active = pending_q & ~mask_q;

        // Later iterations overwrite earlier ones, so the highest set index wins.
        sel = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (active[i]) begin
                sel = ID_WIDTH'(i);
            end
        end

        state_d  = state_q;
        irq_d    = irq_q;
        vector_d = vector_q;
        clr      = '0;

        case (state_q)
            ST_IDLE: begin
                irq_d = 1'b0;
                if (|active) begin
                    vector_d = sel;
                    irq_d    = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                irq_d = 1'b1;
                if (irqAck) begin
                    clr     = IN_WIDTH'(1) << vector_q;
                    irq_d   = 1'b0;
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                irq_d = 1'b0;
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // A rise on the bit being acknowledged re-arms it in the same cycle.
        pending_d  = (pending_q & ~clr) | rise;
        mask_d     = maskWe ? maskIn : mask_q;
        src_prev_d = src;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            irq_q      <= 1'b0;
            vector_q   <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
            src_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            irq_q      <= irq_d;
            vector_q   <= vector_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            src_prev_q <= src_prev_d;
        end
    end

    assign irq       = irq_q;
    assign vector    = vector_q;
    assign pending   = pending_q;
    assign busy      = (state_q == ST_REQ) || (state_q == ST_SERVICE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus randomized traffic for interrupt_controller, each
// cycle checked against a transaction-level reference model.
module tb_interrupt_controller;

  localparam int ID_WIDTH = 3;
  localparam int N        = 1 << ID_WIDTH;

  logic           clk;
  logic           rst;
  logic [N-1:0]   src;
  logic           mask_we;
  logic [N-1:0]   mask_in;
  logic           irq_ack;
  logic           eoi;
  logic           irq;
  logic [ID_WIDTH-1:0] vector;
  logic [N-1:0]   pending;
  logic           busy;
  logic [1:0]     dbg_state;

  int n_compared;
  int n_mismatched;

  // reference model: what the CPU sees, kept as plain bit sets and a phase
  localparam int PH_IDLE = 0, PH_WAIT_ACK = 1, PH_IN_SERVICE = 2;
  int           m_phase;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  logic [N-1:0] m_prev;
  int           m_vec;
  logic         m_irq;

  interrupt_controller #(.ID_WIDTH(ID_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .maskWe    (mask_we),
    .maskIn    (mask_in),
    .irqAck    (irq_ack),
    .eoi       (eoi),
    .irq       (irq),
    .vector    (vector),
    .pending   (pending),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int highest_set(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = i;
        break;
      end
    end
    return r;
  endfunction

  task automatic model_edge();
    logic [N-1:0] rise;
    logic [N-1:0] served;
    int           top;
    if (rst) begin
      m_phase = PH_IDLE;
      m_pend  = '0;
      m_mask  = '1;
      m_prev  = '0;
      m_vec   = 0;
      m_irq   = 1'b0;
      return;
    end
    rise   = src & ~m_prev;
    served = '0;
    top    = highest_set(m_pend & ~m_mask);
    if (m_phase == PH_IDLE) begin
      if (top >= 0) begin
        m_vec   = top;
        m_irq   = 1'b1;
        m_phase = PH_WAIT_ACK;
      end
    end else if (m_phase == PH_WAIT_ACK) begin
      if (irq_ack) begin
        served[m_vec] = 1'b1;
        m_irq   = 1'b0;
        m_phase = PH_IN_SERVICE;
      end
    end else if (eoi) begin
      m_phase = PH_IDLE;
    end
    m_pend = (m_pend & ~served) | rise;
    if (mask_we) m_mask = mask_in;
    m_prev = src;
  endtask

  // driver: one clock edge with the currently driven inputs, then check
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("irq", 32'(irq), 32'(m_irq));
    check_eq("vector", 32'(vector), 32'(m_vec));
    check_eq("pending", 32'(pending), 32'(m_pend));
    check_eq("busy", 32'(busy), 32'(m_phase != PH_IDLE));
  endtask

  task automatic idle_inputs();
    rst = 1'b0; src = '0; mask_we = 1'b0; mask_in = '0; irq_ack = 1'b0; eoi = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we = 1'b1; mask_in = m;
    step();
    mask_we = 1'b0;
  endtask

  task automatic ack_then_eoi();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    m_phase = PH_IDLE; m_pend = '0; m_mask = '1; m_prev = '0; m_vec = 0; m_irq = 1'b0;
    idle_inputs();
    @(negedge clk);

    // reset state
    do_reset();
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_vector", 32'(vector), 32'h0);
    check_eq("rst_pending", 32'(pending), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);

    // single pulse on src[2]
    write_mask(8'h00);
    src = 8'h04; step();
    check_eq("p2_pending", 32'(pending), 32'h04);
    check_eq("p2_irq_early", 32'(irq), 32'h0);
    src = 8'h00; step();
    check_eq("p2_irq", 32'(irq), 32'h1);
    check_eq("p2_vector", 32'(vector), 32'h2);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check_eq("p2_ack_pending", 32'(pending), 32'h00);
    check_eq("p2_ack_irq", 32'(irq), 32'h0);
    check_eq("p2_ack_busy", 32'(busy), 32'h1);
    eoi = 1'b1; step(); eoi = 1'b0;
    check_eq("p2_eoi_busy", 32'(busy), 32'h0);

    // simultaneous src[1] and src[6]
    src = 8'h42; step(); src = 8'h00; step();
    check_eq("pri_first", 32'(vector), 32'h6);
    ack_then_eoi();
    check_eq("pri_pend_left", 32'(pending), 32'h02);
    step();
    check_eq("pri_second", 32'(vector), 32'h1);
    check_eq("pri_second_irq", 32'(irq), 32'h1);
    check_eq("pri_pend_held", 32'(pending), 32'h02);
    ack_then_eoi();

    // masked source after reset, then unmask
    do_reset();
    src = 8'h08; step(); src = 8'h00; step();
    check_eq("mask_pending", 32'(pending), 32'h08);
    check_eq("mask_irq_off", 32'(irq), 32'h0);
    write_mask(8'hF7);
    step();
    check_eq("unmask_irq", 32'(irq), 32'h1);
    check_eq("unmask_vector", 32'(vector), 32'h3);
    ack_then_eoi();
    write_mask(8'h00);

    // higher-priority arrival while waiting for ack
    src = 8'h02; step(); src = 8'h00; step();
    src = 8'h80; step(); src = 8'h00; step();
    check_eq("hold_vector", 32'(vector), 32'h1);
    check_eq("hold_irq", 32'(irq), 32'h1);
    ack_then_eoi();
    step();
    check_eq("late_vector", 32'(vector), 32'h7);
    ack_then_eoi();

    // rise on the bit being acknowledged
    src = 8'h10; step(); src = 8'h00; step();
    src = 8'h10; irq_ack = 1'b1; step(); irq_ack = 1'b0; src = 8'h00;
    check_eq("rerise_pending", 32'(pending), 32'h10);
    eoi = 1'b1; step(); eoi = 1'b0;
    step();
    check_eq("rerise_vector", 32'(vector), 32'h4);
    check_eq("rerise_irq", 32'(irq), 32'h1);
    ack_then_eoi();

    // masking while waiting still allows the ack
    src = 8'h01; step(); src = 8'h00; step();
    write_mask(8'hFF);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check_eq("mask_in_req_busy", 32'(busy), 32'h1);
    eoi = 1'b1; step(); eoi = 1'b0;
    write_mask(8'h00);

    // reset in SERVICE with pending 0x30
    src = 8'h20; step(); src = 8'h00; step();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    src = 8'h30; step(); src = 8'h00;
    check_eq("svc_pending", 32'(pending), 32'h30);
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("svc_rst_irq", 32'(irq), 32'h0);
    check_eq("svc_rst_vector", 32'(vector), 32'h0);
    check_eq("svc_rst_pending", 32'(pending), 32'h00);
    check_eq("svc_rst_busy", 32'(busy), 32'h0);
    irq_ack = 1'b1; eoi = 1'b1; step(); irq_ack = 1'b0; eoi = 1'b0;
    check_eq("stray_busy", 32'(busy), 32'h0);
    src = 8'h01; step(); src = 8'h00; step();
    check_eq("all_masked_irq", 32'(irq), 32'h0);

    // src held through reset release; level-held produces one set only
    src = 8'h01; rst = 1'b1; step(); rst = 1'b0;
    step();
    check_eq("held_rise", 32'(pending), 32'h01);
    write_mask(8'h00);
    step();
    ack_then_eoi();
    step(); step();
    check_eq("held_no_reset", 32'(pending), 32'h00);
    check_eq("held_idle", 32'(irq), 32'h0);
    src = 8'h00; step();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      src     = ($urandom_range(0, 3) == 0) ? N'($urandom) : (src & N'($urandom));
      mask_we = ($urandom_range(0, 15) == 0);
      mask_in = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      eoi     = ($urandom_range(0, 2) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter: ID_WIDTH, default 3, width of the vector ID; derived IN_WIDTH = 1 << ID_WIDTH sources.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 src  input  IN_WIDTH  interrupt request lines, edge-triggered on 0->1.
REQ-005 maskWe  input  1  load mask register from maskIn this cycle.
REQ-006 maskIn  input  IN_WIDTH  new mask value; bit=1 masks the source.
REQ-007 irqAck  input  1  CPU acknowledge of the presented vector.
REQ-008 eoi  input  1  end-of-interrupt; CPU finished servicing.
REQ-009 irq  output  1  interrupt request to the CPU, registered.
REQ-010 vector  output  ID_WIDTH  ID of the presented/in-service source, registered.
REQ-011 pending  output  IN_WIDTH  current pending register, unmasked view.
REQ-012 busy  output  1  high in states REQ and SERVICE.

Function
REQ-013 Edge detect: register srcPrev <= src each cycle; rise = src & ~srcPrev.
REQ-014 pending next = (pending & ~clr) | rise; clr is the one-hot of vector on an accepted ack, else 0; a rise on the cleared bit in the same cycle wins (bit stays 1).
REQ-015 mask register: loaded from maskIn when maskWe=1; otherwise holds; masking never clears pending bits.
REQ-016 active = pending & ~mask, using registered pending and mask.
REQ-017 Selection: highest set index of active wins (bit IN_WIDTH-1 highest priority); pure combinational priority encode, no rotation.
REQ-018 FSM states: IDLE, REQ, SERVICE.
REQ-019 IDLE: if |active, latch vector = selected index, irq <= 1, go REQ; else stay, irq=0.
REQ-020 REQ: irq held 1 and vector held stable regardless of later src, mask or higher-priority arrivals.
REQ-021 REQ + irqAck=1: clear pending[vector], irq <= 0, go SERVICE; vector holds.
REQ-022 SERVICE: irq=0, vector holds; eoi=1 -> IDLE; new rises keep accumulating in pending.
REQ-023 irqAck outside REQ and eoi outside SERVICE are ignored, no state change.
REQ-024 irqAck and eoi both high in REQ: ack only; eoi dropped.
REQ-025 Latency: src sampled high (srcPrev=0) at edge k sets pending at k; irq observed high after edge k+1 if FSM in IDLE and bit unmasked.
REQ-026 Back-to-back: after eoi accepted at edge m, FSM is IDLE for the cycle after m; next irq rises after edge m+1 at earliest.
REQ-027 A source masked while in REQ is still acknowledged normally; masking affects only the next IDLE selection.
REQ-028 Level-held src produces exactly one pending set; a new set requires src to return to 0 for at least one cycle.

Reset
REQ-029 rst=1 at a rising edge: state=IDLE, irq=0, vector=0, pending=0, srcPrev=0, mask=all ones (all sources masked).
REQ-030 Reset has priority over all other inputs including maskWe, irqAck, eoi; reset mid-REQ or mid-SERVICE drops the interrupt with no ack needed.
REQ-031 A src line held high through reset release produces a rise in the first post-reset cycle (srcPrev=0).

Verification
REQ-032 Mask=0x00, pulse src[2] one cycle -> pending=0x04, irq=1 with vector=2 two edges after sample; irqAck -> pending=0x00, irq=0, busy=1; eoi -> busy=0.
REQ-033 Mask=0x00, src[1] and src[6] rise same cycle -> vector=6 first; after ack+eoi, vector=1 presented next, pending=0x02 until its ack.
REQ-034 Reset mask all ones, src[3] rises -> pending=0x08, irq stays 0; write maskIn=0xF7 -> irq=1, vector=3 one edge after mask load.
REQ-035 In REQ with vector=1, src[7] rises -> vector stays 1 until ack; after eoi vector=7 presented.
REQ-036 src[4] rises in the same cycle irqAck clears vector=4 -> pending[4] stays 1, re-presented after eoi.
REQ-037 rst asserted while in SERVICE with pending=0x30 -> next cycle irq=0, vector=0, pending=0x00, mask=0xFF, busy=0; stray eoi/irqAck afterwards ignored.
